branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 br_valid  in  1  conditional branch present in ID.
REQ-005 br_funct3  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-006 pc_id, imm_id  in  32 each  branch PC and sign-extended B-immediate.
REQ-007 fa, fb  in  3 each  operand select codes from the branch forwarding unit.
REQ-008 rf_rs1, rf_rs2  in  32 each  register-file read data (code 000).
REQ-009 ex_result  in  32  EX ALU result (001); ex_is_load  in  1  EX holds a load.
REQ-010 mem_alu, mem_rdata, wb_data  in  32 each  sources for codes 010, 011, 100.
REQ-011 stall  out  1  hold PC and IF/ID.
REQ-012 flush  out  1  kill IF/ID.
REQ-013 redirect_valid  out  1; redirect_pc  out  32  PC load request and target.
REQ-014 br_cnt, tk_cnt  out  16 each  resolved-branch and taken-branch counters.

Function
REQ-015 Operand A SHALL be selected by fa: 000 rf_rs1, 001 ex_result, 010 mem_alu, 011 mem_rdata, 100 wb_data; codes 101-111 select rf_rs1. Operand B likewise by fb with rf_rs2.
REQ-016 Compare: EQ/NE bitwise; LT/GE two's-complement signed; LTU/GEU unsigned; funct3 010/011 SHALL resolve not-taken.
REQ-017 Target SHALL be pc_id + imm_id, modulo 2^32 (wrap, no overflow flag).
REQ-018 FSM states: RESOLVE, WAIT_LD, REDIRECT.
REQ-019 RESOLVE, br_valid=0: all outputs low, stay.
REQ-020 RESOLVE, br_valid=1 and ex_is_load=1 and (fa=001 or fb=001): stall=1 combinationally, go to WAIT_LD, no counter update.
REQ-021 WAIT_LD: stall=0; evaluate the branch exactly as in RESOLVE (forwarding unit now supplies 011), never re-enter WAIT_LD from WAIT_LD.
REQ-022 Evaluation, taken: register redirect_pc=target, go to REDIRECT; br_cnt+1, tk_cnt+1.
REQ-023 Evaluation, not taken: go to RESOLVE; br_cnt+1 only.
REQ-024 REDIRECT: redirect_valid=1 and flush=1 for exactly one cycle, br_valid ignored (wrong-path), return to RESOLVE.
REQ-025 Branch resolution latency: 1 cycle to redirect_valid without load hazard, 2 cycles with.
REQ-026 Counters SHALL wrap at 0xFFFF -> 0x0000.
REQ-027 br_valid dropping while in WAIT_LD SHALL return to RESOLVE with no count and no redirect.

Reset
REQ-028 rst_n low SHALL force state RESOLVE, redirect_pc=0, counters=0, stall/flush/redirect_valid=0 immediately.
REQ-029 Reset asserted in WAIT_LD or REDIRECT SHALL abort the branch; no redirect pulse after release.

Structure
REQ-030 Forward-select codes (000-100), funct3 branch codes and FSM state encodings SHALL live in the shared core package.
REQ-031 The compare SHALL be one sub-module, branch_cmp (operands, funct3 -> taken), purely combinational.

Verification
REQ-032 BEQ, fa=fb=000, rf_rs1=rf_rs2=5, pc_id=0x100, imm_id=0x20 -> next cycle redirect_valid=flush=1, redirect_pc=0x120, br_cnt=1, tk_cnt=1.
REQ-033 BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken, no redirect, br_cnt=2, tk_cnt=1.
REQ-034 BNE, fa=001, ex_is_load=1 -> stall=1 one cycle; then fa=011, mem_rdata=7, rf_rs2=3 -> redirect one cycle later.
REQ-035 pc_id=0xFFFFFFF0, imm_id=0x20, taken -> redirect_pc=0x00000010.
REQ-036 Taken branch followed by br_valid=1 during REDIRECT -> second branch ignored, counters +1 only.
REQ-037 rst_n low during WAIT_LD -> all outputs 0 asynchronously; no redirect after release; 65536 resolutions -> br_cnt=0.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// branch_resolve_pkg: forwarding select codes, branch funct3 codes and resolver FSM states.
package branch_resolve_pkg;

   localparam logic [2:0] FWD_RF      = 3'b000;
   localparam logic [2:0] FWD_EX      = 3'b001;
   localparam logic [2:0] FWD_MEM_ALU = 3'b010;
   localparam logic [2:0] FWD_MEM_LD  = 3'b011;
   localparam logic [2:0] FWD_WB      = 3'b100;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      S_RESOLVE  = 2'b00,
      S_WAIT_LD  = 2'b01,
      S_REDIRECT = 2'b10
   } state_e;

   // Unused select codes fall back to the register file.
   function automatic logic [31:0] fwd_mux(input logic [2:0] sel, input logic [31:0] rf,
                                           input logic [31:0] ex, input logic [31:0] mem_alu,
                                           input logic [31:0] mem_ld, input logic [31:0] wb);
      return sel == FWD_EX      ? ex      :
             sel == FWD_MEM_ALU ? mem_alu :
             sel == FWD_MEM_LD  ? mem_ld  :
             sel == FWD_WB      ? wb      :
             sel == FWD_RF      ? rf      : rf;
   endfunction

endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational branch condition evaluation for the six RV32 conditional branches.
module branch_cmp
   import branch_resolve_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  funct3,
   output logic        taken
);

   logic eq, lt, ltu;

   always_comb begin
      eq    = a == b;
      lt    = $signed(a) < $signed(b);
      ltu   = a < b;
      taken = funct3 == F3_BEQ  ? eq   :
              funct3 == F3_BNE  ? !eq  :
              funct3 == F3_BLT  ? lt   :
              funct3 == F3_BGE  ? !lt  :
              funct3 == F3_BLTU ? ltu  :
              funct3 == F3_BGEU ? !ltu : 1'b0;
   end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: ID-stage branch resolution with load-use stall, one-cycle redirect/flush
// pulse and resolved/taken branch counters.
module branch_resolve
   import branch_resolve_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_valid,
   input  logic [2:0]  br_funct3,
   input  logic [31:0] pc_id,
   input  logic [31:0] imm_id,
   input  logic [2:0]  fa,
   input  logic [2:0]  fb,
   input  logic [31:0] rf_rs1,
   input  logic [31:0] rf_rs2,
   input  logic [31:0] ex_result,
   input  logic        ex_is_load,
   input  logic [31:0] mem_alu,
   input  logic [31:0] mem_rdata,
   input  logic [31:0] wb_data,
   output logic        stall,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [15:0] br_cnt,
   output logic [15:0] tk_cnt
);

   state_e      state_q, state_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic [15:0] br_cnt_q, br_cnt_d;
   logic [15:0] tk_cnt_q, tk_cnt_d;
   logic [31:0] op_a, op_b;
   logic        taken, hazard, eval;

   assign op_a   = fwd_mux(fa, rf_rs1, ex_result, mem_alu, mem_rdata, wb_data);
   assign op_b   = fwd_mux(fb, rf_rs2, ex_result, mem_alu, mem_rdata, wb_data);
   assign hazard = ex_is_load && (fa == FWD_EX || fb == FWD_EX);

   branch_cmp u_cmp (
      .a      (op_a),
      .b      (op_b),
      .funct3 (br_funct3),
      .taken  (taken)
   );

   always_comb begin
      state_d        = state_q;
      redirect_pc_d  = redirect_pc_q;
      br_cnt_d       = br_cnt_q;
      tk_cnt_d       = tk_cnt_q;
      stall          = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      eval           = 1'b0;
      case (state_q)
         S_RESOLVE: begin
            if (br_valid && hazard) begin
               stall   = rst_n;
               state_d = S_WAIT_LD;
            end else begin
               eval = br_valid;
            end
         end
         S_WAIT_LD: begin
            eval    = br_valid;
            state_d = S_RESOLVE;
         end
         S_REDIRECT: begin
            redirect_valid = 1'b1;
            flush          = 1'b1;
            state_d        = S_RESOLVE;
         end
         default: state_d = S_RESOLVE;
      endcase
      if (eval) begin
         br_cnt_d = br_cnt_q + 16'd1;
         state_d  = taken ? S_REDIRECT : S_RESOLVE;
         if (taken) begin
            tk_cnt_d      = tk_cnt_q + 16'd1;
            redirect_pc_d = pc_id + imm_id;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_RESOLVE;
         redirect_pc_q <= 32'd0;
         br_cnt_q      <= 16'd0;
         tk_cnt_q      <= 16'd0;
      end else begin
         state_q       <= state_d;
         redirect_pc_q <= redirect_pc_d;
         br_cnt_q      <= br_cnt_d;
         tk_cnt_q      <= tk_cnt_d;
      end
   end

   assign redirect_pc = redirect_pc_q;
   assign br_cnt      = br_cnt_q;
   assign tk_cnt      = tk_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed vectors with hand-computed expectations for branch_resolve.
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_valid;
   logic [2:0]  br_funct3;
   logic [31:0] pc_id, imm_id;
   logic [2:0]  fa, fb;
   logic [31:0] rf_rs1, rf_rs2, ex_result, mem_alu, mem_rdata, wb_data;
   logic        ex_is_load;
   logic        stall, flush, redirect_valid;
   logic [31:0] redirect_pc;
   logic [15:0] br_cnt, tk_cnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   branch_resolve dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .br_valid       (br_valid),
      .br_funct3      (br_funct3),
      .pc_id          (pc_id),
      .imm_id         (imm_id),
      .fa             (fa),
      .fb             (fb),
      .rf_rs1         (rf_rs1),
      .rf_rs2         (rf_rs2),
      .ex_result      (ex_result),
      .ex_is_load     (ex_is_load),
      .mem_alu        (mem_alu),
      .mem_rdata      (mem_rdata),
      .wb_data        (wb_data),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .br_cnt         (br_cnt),
      .tk_cnt         (tk_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      br_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      rst_n    = 1'b1;
   endtask

   // Present one hazard-free branch for a single cycle; returns one cycle later.
   task automatic branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm);
      br_funct3  = f3;
      rf_rs1     = a;
      rf_rs2     = b;
      pc_id      = pc;
      imm_id     = imm;
      fa         = 3'b000;
      fb         = 3'b000;
      ex_is_load = 1'b0;
      br_valid   = 1'b1;
      tick();
      br_valid   = 1'b0;
   endtask

   function automatic logic [31:0] src_val(input logic [2:0] code, input logic [31:0] rf);
      return code == 3'd1 ? 32'h22 : code == 3'd2 ? 32'h33 : code == 3'd3 ? 32'h44 :
             code == 3'd4 ? 32'h55 : rf;
   endfunction

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic        tk;
   } vec_t;

   vec_t vecs[11] = '{
      '{3'b000, 32'd5,          32'd6,          1'b0},
      '{3'b001, 32'd5,          32'd6,          1'b1},
      '{3'b100, 32'hFFFFFFFF,   32'd1,          1'b1},
      '{3'b110, 32'hFFFFFFFF,   32'd1,          1'b0},
      '{3'b101, 32'd1,          32'hFFFFFFFF,   1'b1},
      '{3'b111, 32'd1,          32'hFFFFFFFF,   1'b0},
      '{3'b101, 32'd3,          32'd3,          1'b1},
      '{3'b111, 32'h80000000,   32'h7FFFFFFF,   1'b1},
      '{3'b100, 32'h80000000,   32'h7FFFFFFF,   1'b1},
      '{3'b010, 32'd5,          32'd5,          1'b0},
      '{3'b011, 32'd5,          32'd5,          1'b0}
   };

   initial begin
      rst_n = 1'b0; br_valid = 1'b0; br_funct3 = 3'b000; pc_id = 32'd0; imm_id = 32'd0;
      fa = 3'b000; fb = 3'b000; rf_rs1 = 32'd0; rf_rs2 = 32'd0; ex_result = 32'h22;
      mem_alu = 32'h33; mem_rdata = 32'h44; wb_data = 32'h55; ex_is_load = 1'b0;
      #3;
      check("rst_stall", stall, 0);
      check("rst_flush", flush, 0);
      check("rst_rv", redirect_valid, 0);
      check("rst_rpc", redirect_pc, 0);
      check("rst_br", br_cnt, 0);
      check("rst_tk", tk_cnt, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("idle_rv", redirect_valid, 0);

      // BEQ taken, one-cycle latency
      branch(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
      check("beq_rv", redirect_valid, 1);
      check("beq_flush", flush, 1);
      check("beq_rpc", redirect_pc, 32'h120);
      check("beq_br", br_cnt, 1);
      check("beq_tk", tk_cnt, 1);
      tick();
      check("beq_rv_end", redirect_valid, 0);
      check("beq_flush_end", flush, 0);

      // BLT taken then BLTU not taken on the same operands
      do_reset();
      tick();
      branch(3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40);
      check("blt_rv", redirect_valid, 1);
      check("blt_rpc", redirect_pc, 32'h240);
      tick();
      branch(3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40);
      check("bltu_rv", redirect_valid, 0);
      check("bltu_br", br_cnt, 2);
      check("bltu_tk", tk_cnt, 1);

      // Compare table
      foreach (vecs[i]) begin
         branch(vecs[i].f3, vecs[i].a, vecs[i].b, 32'h400, 32'h8);
         check($sformatf("cmp%0d_rv", i), redirect_valid, vecs[i].tk);
         tick();
      end

      // Operand forwarding selects for A then B
      for (int c = 0; c < 8; c++) begin
         rf_rs1 = 32'h11; rf_rs2 = src_val(3'(c), 32'h11);
         br_funct3 = 3'b000; fa = 3'(c); fb = 3'b000; ex_is_load = 1'b0; br_valid = 1'b1;
         tick();
         br_valid = 1'b0;
         check($sformatf("fa%0d_rv", c), redirect_valid, 1);
         tick();
         rf_rs2 = 32'h66; rf_rs1 = src_val(3'(c), 32'h66);
         fa = 3'b000; fb = 3'(c); br_valid = 1'b1;
         tick();
         br_valid = 1'b0;
         check($sformatf("fb%0d_rv", c), redirect_valid, 1);
         tick();
      end

      // Load-use hazard: stall one cycle, redirect two cycles after presentation
      do_reset();
      tick();
      br_funct3 = 3'b001; fa = 3'b001; fb = 3'b000; ex_is_load = 1'b1; rf_rs2 = 32'd3;
      ex_result = 32'd3; pc_id = 32'h300; imm_id = 32'h10; br_valid = 1'b1;
      #1;
      check("ld_stall", stall, 1);
      tick();
      fa = 3'b011; ex_is_load = 1'b0; mem_rdata = 32'd7;
      #1;
      check("ld_wait_stall", stall, 0);
      check("ld_wait_rv", redirect_valid, 0);
      check("ld_wait_br", br_cnt, 0);
      tick();
      br_valid = 1'b0;
      check("ld_rv", redirect_valid, 1);
      check("ld_rpc", redirect_pc, 32'h310);
      check("ld_br", br_cnt, 1);
      check("ld_tk", tk_cnt, 1);
      tick();

      // Hazard inputs still present in WAIT_LD: resolve, never stall again
      fa = 3'b001; ex_is_load = 1'b1; ex_result = 32'd9; rf_rs2 = 32'd3; br_valid = 1'b1;
      tick();
      #1;
      check("ld2_wait_stall", stall, 0);
      tick();
      br_valid = 1'b0;
      check("ld2_rv", redirect_valid, 1);
      check("ld2_br", br_cnt, 2);
      tick();

      // br_valid drops in WAIT_LD
      br_valid = 1'b1;
      tick();
      br_valid = 1'b0;
      tick();
      check("drop_rv", redirect_valid, 0);
      check("drop_br", br_cnt, 2);
      tick();
      check("drop_rv2", redirect_valid, 0);
      ex_is_load = 1'b0;

      // Target wraps modulo 2^32
      branch(3'b000, 32'd1, 32'd1, 32'hFFFFFFF0, 32'h20);
      check("wrap_rpc", redirect_pc, 32'h10);
      tick();

      // Wrong-path branch during REDIRECT is ignored
      branch(3'b000, 32'd1, 32'd1, 32'h500, 32'h4);
      br_valid = 1'b1; pc_id = 32'h900;
      check("wp_rv", redirect_valid, 1);
      check("wp_br", br_cnt, 4);
      tick();
      br_valid = 1'b0;
      check("wp_rv_end", redirect_valid, 0);
      check("wp_br_end", br_cnt, 4);
      check("wp_tk_end", tk_cnt, 4);
      check("wp_rpc", redirect_pc, 32'h504);

      // Reset during WAIT_LD
      fa = 3'b001; ex_is_load = 1'b1; ex_result = 32'd9; rf_rs2 = 32'd3; br_funct3 = 3'b001;
      br_valid = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rwl_stall", stall, 0);
      check("rwl_rv", redirect_valid, 0);
      check("rwl_flush", flush, 0);
      check("rwl_rpc", redirect_pc, 0);
      check("rwl_br", br_cnt, 0);
      check("rwl_tk", tk_cnt, 0);
      br_valid = 1'b0; ex_is_load = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("rwl_post_rv", redirect_valid, 0);
      tick();
      check("rwl_post_rv2", redirect_valid, 0);
      check("rwl_post_br", br_cnt, 0);

      // Reset during REDIRECT
      branch(3'b000, 32'd1, 32'd1, 32'h600, 32'h4);
      check("rrd_rv", redirect_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rrd_rv_rst", redirect_valid, 0);
      check("rrd_flush_rst", flush, 0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rrd_post_rv", redirect_valid, 0);

      // Counter wrap: 65536 not-taken resolutions
      do_reset();
      br_funct3 = 3'b000; fa = 3'b000; fb = 3'b000; rf_rs1 = 32'd1; rf_rs2 = 32'd2;
      ex_is_load = 1'b0; br_valid = 1'b1;
      for (int i = 0; i < 65535; i++) tick();
      check("cnt_ffff", br_cnt, 16'hFFFF);
      check("cnt_tk0", tk_cnt, 0);
      tick();
      br_valid = 1'b0;
      check("cnt_wrap", br_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
